sram_arbiter: RTL and testbench

Shares the single external SRAM between the Z80 (user/expansion RAM windows) and a secondary byte-wide DMA requester, e.g. a tape/snapshot loader. Sits between the CPU bus, the memory decode enables and the `ext_sram_*` pins. It sequences each access over a fixed number of `clk65` cycles, stalls the CPU through `wait_n` while the SRAM is busy, and gives the DMA port idle slots with a starvation guard.

---
 rtl/jace_sram_pkg.sv | 15 +
 rtl/sram_arbiter.sv | 176 +++++++++++++++++
 tb/tb_sram_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jace_sram_pkg.sv
// Shared definitions for the external SRAM arbiter: the FSM state type and
// the SRAM address width.
package jace_sram_pkg;

    localparam int SRAM_AW = 21;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CPU_ACC  = 3'd1,
        CPU_HOLD = 3'd2,
        DMA_ACC  = 3'd3,
        DMA_END  = 3'd4
    } sram_state_t;

endpackage : jace_sram_pkg

// File: rtl/sram_arbiter.sv
// Shares the external SRAM between the Z80 (through WAIT stalls) and a
// byte-wide DMA requester, one fixed-length access at a time.
//
// DMA handshake: dma_req is a level that the requester holds, with stable
// dma_we/dma_addr/dma_wdata, until it sees dma_ack. dma_ack is a one-cycle
// pulse that marks completion; dma_rdata is valid in that same cycle. The
// request is only sampled in IDLE, so a request still high during the ack
// cycle is not mistaken for a new one. Once an access has started it always
// completes and acks, even if dma_req is withdrawn early.
module sram_arbiter
    import jace_sram_pkg::*;
#(
    parameter int ACC_CYCLES   = 2,
    parameter int STARVE_LIMIT = 64
) (
    input  logic               clk65,
    input  logic               reset_n,
    input  logic [15:0]        cpu_addr,
    input  logic               cpu_mreq_n,
    input  logic               cpu_rd_n,
    input  logic               cpu_wr_n,
    input  logic               cpu_sel,
    input  logic [7:0]         cpu_wdata,
    output logic [7:0]         cpu_rdata,
    output logic               cpu_wait_n,
    input  logic               dma_req,
    input  logic               dma_we,
    input  logic [SRAM_AW-1:0] dma_addr,
    input  logic [7:0]         dma_wdata,
    output logic               dma_ack,
    output logic [7:0]         dma_rdata,
    output logic [SRAM_AW-1:0] ext_sram_addr,
    output logic [7:0]         data_to_sram,
    input  logic [7:0]         data_from_sram,
    output logic               sram_we_n,
    output logic               sram_oe_n,
    output sram_state_t        dbg_state
);

    localparam int ACC_W = $clog2(ACC_CYCLES + 1);
    localparam int ST_W  = $clog2(STARVE_LIMIT + 1);
    localparam logic [ACC_W-1:0] ACC_LAST = ACC_W'(ACC_CYCLES);
    localparam logic [ST_W-1:0]  ST_MAX   = ST_W'(STARVE_LIMIT);

    sram_state_t        r_state;
    logic [ACC_W-1:0]   r_acc_cnt;
    logic [ST_W-1:0]    r_starve;
    logic               r_is_write;
    logic [SRAM_AW-1:0] r_addr;
    logic [7:0]         r_wdata;
    logic               r_we_n;
    logic               r_oe_n;
    logic [7:0]         r_cpu_rdata;
    logic [7:0]         r_dma_rdata;
    logic               r_dma_ack;

    logic w_cpu_req;
    logic w_starved;
    logic w_cpu_grant;
    logic w_dma_grant;
    logic w_acc_last;

    assign w_cpu_req   = cpu_sel & ~cpu_mreq_n & (~cpu_rd_n | ~cpu_wr_n);
    assign w_starved   = (r_starve == ST_MAX);
    // The CPU wins ties in IDLE unless the DMA side has waited long enough.
    assign w_cpu_grant = (r_state == IDLE) & w_cpu_req & ~(w_starved & dma_req);
    assign w_dma_grant = (r_state == IDLE) & dma_req & ~w_cpu_grant;
    assign w_acc_last  = (r_acc_cnt == ACC_LAST);

    // Stall the CPU whenever it requests and its access has not finished yet.
    assign cpu_wait_n    = ~(w_cpu_req & (r_state != CPU_HOLD));
    assign cpu_rdata     = r_cpu_rdata;
    assign dma_ack       = r_dma_ack;
    assign dma_rdata     = r_dma_rdata;
    assign ext_sram_addr = r_addr;
    assign data_to_sram  = r_wdata;
    assign sram_we_n     = r_we_n;
    assign sram_oe_n     = r_oe_n;
    assign dbg_state     = r_state;

    // Starvation guard: age a waiting DMA request, restart when it is granted.
    always_ff @(posedge clk65 or negedge reset_n) begin
        if (!reset_n) begin
            r_starve <= '0;
        end else if (w_dma_grant) begin
            r_starve <= '0;
        end else if (dma_req && !r_dma_ack && !w_starved) begin
            r_starve <= r_starve + ST_W'(1);
        end
    end

    // Arbitration FSM with registered SRAM strobes, address, data and acks.
    always_ff @(posedge clk65 or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_acc_cnt   <= '0;
            r_is_write  <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_we_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_cpu_rdata <= '0;
            r_dma_rdata <= '0;
            r_dma_ack   <= 1'b0;
        end else begin
            r_dma_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_cpu_grant) begin
                        r_state    <= CPU_ACC;
                        r_acc_cnt  <= ACC_W'(1);
                        r_addr     <= {5'b00000, cpu_addr};
                        r_is_write <= ~cpu_wr_n;
                        if (!cpu_wr_n) begin
                            r_wdata <= cpu_wdata;
                            r_we_n  <= 1'b0;
                        end else begin
                            r_oe_n  <= 1'b0;
                        end
                    end else if (w_dma_grant) begin
                        r_state    <= DMA_ACC;
                        r_acc_cnt  <= ACC_W'(1);
                        r_addr     <= dma_addr;
                        r_is_write <= dma_we;
                        if (dma_we) begin
                            r_wdata <= dma_wdata;
                            r_we_n  <= 1'b0;
                        end else begin
                            r_oe_n  <= 1'b0;
                        end
                    end
                end
                CPU_ACC: begin
                    if (w_acc_last) begin
                        r_we_n  <= 1'b1;
                        r_oe_n  <= 1'b1;
                        r_state <= CPU_HOLD;
                        if (!r_is_write) begin
                            r_cpu_rdata <= data_from_sram;
                        end
                    end else begin
                        r_acc_cnt <= r_acc_cnt + ACC_W'(1);
                    end
                end
                CPU_HOLD: begin
                    // One access per bus cycle: wait for the strobes to go away.
                    if (!w_cpu_req) begin
                        r_state <= IDLE;
                    end
                end
                DMA_ACC: begin
                    if (w_acc_last) begin
                        r_we_n    <= 1'b1;
                        r_oe_n    <= 1'b1;
                        r_dma_ack <= 1'b1;
                        r_state   <= DMA_END;
                        if (!r_is_write) begin
                            r_dma_rdata <= data_from_sram;
                        end
                    end else begin
                        r_acc_cnt <= r_acc_cnt + ACC_W'(1);
                    end
                end
                DMA_END: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_we_n  <= 1'b1;
                    r_oe_n  <= 1'b1;
                end
            endcase
        end
    end

endmodule : sram_arbiter

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: behavioural SRAM device, directed scenarios and a
// randomized mix of CPU/DMA reads and writes checked against a byte-level
// memory model.
module tb_sram_arbiter;
    import jace_sram_pkg::*;

    localparam int ACC_CYCLES   = 2;
    localparam int STARVE_LIMIT = 64;
    localparam int TIMEOUT      = 500;

    // ---------------- clock / reset ----------------
    logic clk65 = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk65 = ~clk65;

    logic [15:0]        cpu_addr = '0;
    logic               cpu_mreq_n = 1'b1;
    logic               cpu_rd_n = 1'b1;
    logic               cpu_wr_n = 1'b1;
    logic               cpu_sel = 1'b0;
    logic [7:0]         cpu_wdata = '0;
    logic [7:0]         cpu_rdata;
    logic               cpu_wait_n;
    logic               dma_req = 1'b0;
    logic               dma_we = 1'b0;
    logic [SRAM_AW-1:0] dma_addr = '0;
    logic [7:0]         dma_wdata = '0;
    logic               dma_ack;
    logic [7:0]         dma_rdata;
    logic [SRAM_AW-1:0] ext_sram_addr;
    logic [7:0]         data_to_sram;
    logic [7:0]         data_from_sram = 8'h00;
    logic               sram_we_n;
    logic               sram_oe_n;
    sram_state_t        dbg_state;

    sram_arbiter #(.ACC_CYCLES(ACC_CYCLES), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk65(clk65), .reset_n(reset_n),
        .cpu_addr(cpu_addr), .cpu_mreq_n(cpu_mreq_n), .cpu_rd_n(cpu_rd_n),
        .cpu_wr_n(cpu_wr_n), .cpu_sel(cpu_sel), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_wait_n(cpu_wait_n),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .ext_sram_addr(ext_sram_addr), .data_to_sram(data_to_sram),
        .data_from_sram(data_from_sram), .sram_we_n(sram_we_n),
        .sram_oe_n(sram_oe_n), .dbg_state(dbg_state)
    );

    // ---------------- SRAM device model + strobe monitor ----------------
    logic [7:0]         sram_arr [logic [SRAM_AW-1:0]];
    int                 we_pulses = 0, oe_pulses = 0, ack_pulses = 0;
    int                 we_len = 0, oe_len = 0, last_we_len = 0, last_oe_len = 0;
    int                 overlap = 0;
    logic [SRAM_AW-1:0] strobe_addr = '0;
    logic [7:0]         strobe_wdata = '0;

    always @(negedge clk65) begin
        if (dma_ack) ack_pulses++;
        if (!sram_we_n && !sram_oe_n) overlap++;
        if (!sram_we_n) begin
            if (we_len == 0) we_pulses++;
            we_len++;
            sram_arr[ext_sram_addr] = data_to_sram;
            strobe_addr  = ext_sram_addr;
            strobe_wdata = data_to_sram;
        end else if (we_len != 0) begin
            last_we_len = we_len;
            we_len = 0;
        end
        if (!sram_oe_n) begin
            if (oe_len == 0) oe_pulses++;
            oe_len++;
            strobe_addr = ext_sram_addr;
            data_from_sram = sram_arr.exists(ext_sram_addr) ? sram_arr[ext_sram_addr] : 8'h00;
        end else begin
            if (oe_len != 0) begin
                last_oe_len = oe_len;
                oe_len = 0;
            end
            data_from_sram = 8'h00;
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] ref_mem [logic [SRAM_AW-1:0]];
    logic [7:0] exp_q [$];

    function automatic logic [7:0] ref_rd(input logic [SRAM_AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    time t_cpu_drop = 0;
    time t_dma_ack = 0;

    task automatic cpu_access(input logic is_wr, input logic [15:0] a, input logic [7:0] wd,
                              input int hold, output logic [7:0] rd, output int waits);
        @(posedge clk65); #1;
        cpu_addr   = a;
        cpu_wdata  = wd;
        cpu_sel    = 1'b1;
        cpu_mreq_n = 1'b0;
        cpu_rd_n   = is_wr;
        cpu_wr_n   = ~is_wr;
        waits = 0;
        forever begin
            @(negedge clk65);
            if (cpu_wait_n) break;
            waits++;
            if (waits > TIMEOUT) break;
        end
        rd = cpu_rdata;
        repeat (hold) @(negedge clk65);
        @(posedge clk65); #1;
        cpu_sel    = 1'b0;
        cpu_mreq_n = 1'b1;
        cpu_rd_n   = 1'b1;
        cpu_wr_n   = 1'b1;
        t_cpu_drop = $time;
    endtask

    task automatic dma_access(input logic we, input logic [SRAM_AW-1:0] a, input logic [7:0] wd,
                              output logic [7:0] rd, output int lat);
        @(posedge clk65); #1;
        dma_req   = 1'b1;
        dma_we    = we;
        dma_addr  = a;
        dma_wdata = wd;
        lat = 0;
        forever begin
            @(negedge clk65);
            if (dma_ack) break;
            lat++;
            if (lat > TIMEOUT) break;
        end
        t_dma_ack = $time;
        rd = dma_rdata;
        @(posedge clk65); #1;
        dma_req = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        logic [7:0]  rd, rd2, exp_b;
        int          waits, lat, max_wait, snap_we, snap_oe, snap_ack, iter;
        bit          dma_done;
        logic [15:0] pool [6];
        logic [15:0] a16;
        logic [SRAM_AW-1:0] a21;
        int          kind;
        pool = '{16'h4000, 16'h8123, 16'h0001, 16'hFFFF, 16'h5A5A, 16'h1234};

        // Reset state
        repeat (3) @(negedge clk65);
        check("rst_we_n",   32'(sram_we_n), 32'd1);
        check("rst_oe_n",   32'(sram_oe_n), 32'd1);
        check("rst_addr",   32'(ext_sram_addr), 32'd0);
        check("rst_wdata",  32'(data_to_sram), 32'd0);
        check("rst_cpu_rd", 32'(cpu_rdata), 32'd0);
        check("rst_dma_rd", 32'(dma_rdata), 32'd0);
        check("rst_ack",    32'(dma_ack), 32'd0);
        check("rst_wait_n", 32'(cpu_wait_n), 32'd1);
        check("rst_state",  32'(dbg_state), 32'(IDLE));
        reset_n = 1'b1;
        repeat (2) @(negedge clk65);

        // Preload 0x4000 = 0xA5 through the DMA port, then CPU read
        dma_access(1'b1, 21'h004000, 8'hA5, rd, lat);
        ref_mem[21'h004000] = 8'hA5;
        snap_oe = oe_pulses; snap_we = we_pulses;
        cpu_access(1'b0, 16'h4000, 8'h00, 0, rd, waits);
        check("cpu_rd_data",  32'(rd), 32'(ref_rd(21'h004000)));
        check("cpu_rd_waits", 32'(waits), 32'(ACC_CYCLES + 1));
        check("cpu_rd_oe_pulses", 32'(oe_pulses - snap_oe), 32'd1);
        check("cpu_rd_oe_len",    32'(last_oe_len), 32'(ACC_CYCLES));
        check("cpu_rd_addr",      32'(strobe_addr), 32'h004000);
        check("cpu_rd_no_we",     32'(we_pulses - snap_we), 32'd0);

        // CPU write held for extra cycles: single write pulse only
        snap_we = we_pulses;
        cpu_access(1'b1, 16'h8123, 8'h3C, 6, rd, waits);
        ref_mem[21'h008123] = 8'h3C;
        repeat (2) @(negedge clk65);
        check("cpu_wr_pulses", 32'(we_pulses - snap_we), 32'd1);
        check("cpu_wr_len",    32'(last_we_len), 32'(ACC_CYCLES));
        check("cpu_wr_data",   32'(strobe_wdata), 32'h3C);
        check("cpu_wr_addr",   32'(strobe_addr), 32'h008123);
        check("cpu_wr_waits",  32'(waits), 32'(ACC_CYCLES + 1));
        check("cpu_wr_mem",    32'(sram_arr[21'h008123]), 32'(ref_rd(21'h008123)));

        // DMA write then read back at the top of the address space
        dma_access(1'b1, 21'h1F0000, 8'h5A, rd, lat);
        ref_mem[21'h1F0000] = 8'h5A;
        check("dma_wr_lat", 32'(lat), 32'(ACC_CYCLES + 1));
        dma_access(1'b0, 21'h1F0000, 8'h00, rd, lat);
        check("dma_rd_lat",  32'(lat), 32'(ACC_CYCLES + 1));
        check("dma_rd_data", 32'(rd), 32'(ref_rd(21'h1F0000)));

        // Same-cycle CPU and DMA requests: CPU first, DMA after CPU drops
        fork
            cpu_access(1'b0, 16'h8123, 8'h00, 1, rd, waits);
            dma_access(1'b0, 21'h1F0000, 8'h00, rd2, lat);
        join
        check("tie_cpu_waits", 32'(waits), 32'(ACC_CYCLES + 1));
        check("tie_cpu_data",  32'(rd), 32'(ref_rd(21'h008123)));
        check("tie_dma_data",  32'(rd2), 32'(ref_rd(21'h1F0000)));
        check("tie_dma_after_cpu", 32'(t_dma_ack > t_cpu_drop), 32'd1);

        // Back-to-back CPU traffic with DMA pending: starvation guard
        dma_done = 1'b0;
        max_wait = 0;
        iter = 0;
        fork
            begin
                dma_access(1'b0, 21'h004000, 8'h00, rd2, lat);
                dma_done = 1'b1;
            end
            begin
                while (!dma_done && iter < 100) begin
                    cpu_access(1'b0, 16'h8123, 8'h00, 0, rd, waits);
                    if (waits > max_wait) max_wait = waits;
                    iter++;
                end
            end
        join
        check("starve_lat_bound",
              32'((lat >= STARVE_LIMIT) && (lat <= STARVE_LIMIT + 2 * ACC_CYCLES + 6)), 32'd1);
        check("starve_dma_data", 32'(rd2), 32'(ref_rd(21'h004000)));
        check("starve_cpu_stalled", 32'(max_wait > ACC_CYCLES + 1), 32'd1);
        repeat (4) @(negedge clk65);

        // Reset during DMA_ACC
        snap_ack = ack_pulses;
        @(posedge clk65); #1;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 21'h0ABCDE; dma_wdata = 8'h77;
        @(negedge clk65);
        @(negedge clk65);
        check("mid_dma_we_low", 32'(sram_we_n), 32'd0);
        #2 reset_n = 1'b0;
        #1;
        check("rst_async_we_n", 32'(sram_we_n), 32'd1);
        check("rst_async_oe_n", 32'(sram_oe_n), 32'd1);
        dma_req = 1'b0;
        repeat (2) @(negedge clk65);
        reset_n = 1'b1;
        repeat (6) @(negedge clk65);
        check("rst_no_ack",    32'(ack_pulses - snap_ack), 32'd0);
        check("rst_idle",      32'(dbg_state), 32'(IDLE));

        // Randomized mix against the byte memory model
        for (int i = 0; i < 24; i++) begin
            kind = int'($urandom_range(0, 3));
            a16  = pool[$urandom_range(0, 5)];
            a21  = ($urandom_range(0, 1) == 1) ? {5'h1F, a16} : {5'h00, a16};
            exp_b = 8'($urandom_range(0, 255));
            case (kind)
                0: begin
                    cpu_access(1'b1, a16, exp_b, int'($urandom_range(0, 2)), rd, waits);
                    ref_mem[{5'h00, a16}] = exp_b;
                    check("rnd_cpu_wr_waits", 32'(waits), 32'(ACC_CYCLES + 1));
                end
                1: begin
                    exp_q.push_back(ref_rd({5'h00, a16}));
                    cpu_access(1'b0, a16, 8'h00, int'($urandom_range(0, 2)), rd, waits);
                    check("rnd_cpu_rd_data", 32'(rd), 32'(exp_q.pop_front()));
                    check("rnd_cpu_rd_waits", 32'(waits), 32'(ACC_CYCLES + 1));
                end
                2: begin
                    dma_access(1'b1, a21, exp_b, rd, lat);
                    ref_mem[a21] = exp_b;
                    check("rnd_dma_wr_lat", 32'(lat), 32'(ACC_CYCLES + 1));
                end
                default: begin
                    exp_q.push_back(ref_rd(a21));
                    dma_access(1'b0, a21, 8'h00, rd, lat);
                    check("rnd_dma_rd_data", 32'(rd), 32'(exp_q.pop_front()));
                    check("rnd_dma_rd_lat", 32'(lat), 32'(ACC_CYCLES + 1));
                end
            endcase
        end

        repeat (3) @(negedge clk65);
        check("no_we_oe_overlap", 32'(overlap), 32'd0);

        // ---------------- final report ----------------
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_sram_arbiter
